// File: rtl/pixie_vram_arbiter.sv
// Purpose: one-port VRAM arbiter shared by the buffered DMA write stream, scan-out reads and host port.
// Latency: grant, ack and ram_* are combinational in cycle N; read data and rvalid appear in N+1.
// Backpressure: none on DMA (full FIFO forces a pop); scan/host hold req until ack; host boosted after HOST_MAX_WAIT.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data            DMA write stream, pushed into the write FIFO
//   sc_req/sc_addr                   scan-out read request
//   sc_ack/sc_rdata/sc_rvalid        scan-out grant and read return
//   host_req/host_we/host_addr/host_wdata   host request
//   host_ack/host_rdata/host_rvalid  host grant and read return
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata   synchronous VRAM port
//   wfifo_level                      DMA FIFO occupancy, 0..WFIFO_DEPTH
module pixie_vram_arbiter #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 8,
    parameter int WFIFO_DEPTH   = 4,
    parameter int HOST_MAX_WAIT = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           sc_req,
    input  logic [ADDR_W-1:0]              sc_addr,
    output logic                           sc_ack,
    output logic [DATA_W-1:0]              sc_rdata,
    output logic                           sc_rvalid,
    input  logic                           host_req,
    input  logic                           host_we,
    input  logic [ADDR_W-1:0]              host_addr,
    input  logic [DATA_W-1:0]              host_wdata,
    output logic                           host_ack,
    output logic [DATA_W-1:0]              host_rdata,
    output logic                           host_rvalid,
    output logic                           ram_en,
    output logic                           ram_we,
    output logic [ADDR_W-1:0]              ram_addr,
    output logic [DATA_W-1:0]              ram_wdata,
    input  logic [DATA_W-1:0]              ram_rdata,
    output logic [$clog2(WFIFO_DEPTH):0]   wfifo_level
);

    localparam int PTR_W  = $clog2(WFIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_POP  = 2'd1,
        G_HOST = 2'd2,
        G_SCAN = 2'd3
    } grant_e;

    logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;
    logic [WAIT_W-1:0] wait_cnt;

    logic   fifo_empty;
    logic   fifo_full;
    logic   host_boost;
    logic   push;
    logic   pop;
    grant_e grant;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == LVL_W'(WFIFO_DEPTH));
    assign host_boost = (wait_cnt == WAIT_W'(HOST_MAX_WAIT));
    assign push       = wr_en;
    assign pop        = (grant == G_POP);

    // Host reads wait behind buffered DMA data so the host always sees every
    // byte already pushed; a boosted host read drains the FIFO ahead of scan.
    always_comb begin
        grant = G_NONE;
        if (fifo_full)
            grant = G_POP;
        else if (host_boost && host_req && (fifo_empty || host_we))
            grant = G_HOST;
        else if (host_boost && !fifo_empty)
            grant = G_POP;
        else if (sc_req)
            grant = G_SCAN;
        else if (!fifo_empty)
            grant = G_POP;
        else if (host_req && (host_we || fifo_empty))
            grant = G_HOST;
    end

    assign sc_ack      = (grant == G_SCAN);
    assign host_ack    = (grant == G_HOST);
    assign sc_rdata    = ram_rdata;
    assign host_rdata  = ram_rdata;
    assign wfifo_level = count;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (grant)
            G_POP: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = fifo_addr[rd_ptr];
                ram_wdata = fifo_data[rd_ptr];
            end
            G_HOST: begin
                ram_en    = 1'b1;
                ram_we    = host_we;
                ram_addr  = host_addr;
                ram_wdata = host_we ? host_wdata : '0;
            end
            G_SCAN: begin
                ram_en    = 1'b1;
                ram_addr  = sc_addr;
            end
            default: ;
        endcase
    end

    // Entry storage carries no reset: pointer/count reset makes old contents unreachable.
    // On a simultaneous push and pop while full, wr_ptr equals rd_ptr; the head is
    // consumed combinationally this cycle before being overwritten at the edge.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wait_cnt    <= '0;
            sc_rvalid   <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: ;
            endcase

            if (!host_req || host_ack)
                wait_cnt <= '0;
            else if (!host_boost)
                wait_cnt <= wait_cnt + WAIT_W'(1);

            sc_rvalid   <= (grant == G_SCAN);
            host_rvalid <= (grant == G_HOST) && !host_we;
        end
    end

endmodule
